// File: rtl/rmgmt_seq_pkg.sv
// Shared types and constants for the RISC-MGMT extension sequencer.
`ifndef NUM_EXTENSIONS
`define NUM_EXTENSIONS 4
`endif

package rmgmt_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MEM  = 2'd2
   } rmgmt_seq_state_t;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int WD_W            = 8;

endpackage

// File: rtl/rmgmt_prio_enc.sv
// Lowest-index-first one-hot priority encoder.
module rmgmt_prio_enc #(
   parameter int W = 4
) (
   input  logic [W-1:0] req,
   output logic [W-1:0] sel,
   output logic         any_valid
);

   // Two's-complement isolate-lowest-set-bit.
   assign sel       = req & (~req + W'(1));
   assign any_valid = |req;

endmodule

// File: rtl/rmgmt_ext_sequencer.sv
// Owns one extension instruction at a time: arbitration, start pulse,
// memory-phase tracking, hazard outputs and a watchdog on hung extensions.
module rmgmt_ext_sequencer
   import rmgmt_seq_pkg::*;
#(
   parameter int NUM_EXT = `NUM_EXTENSIONS,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               insn_valid,
   input  logic [NUM_EXT-1:0] ext_claim,
   input  logic               pipe_stall,
   input  logic               flush,
   input  logic [NUM_EXT-1:0] ext_done,
   input  logic [NUM_EXT-1:0] ext_mem_req,
   input  logic [NUM_EXT-1:0] ext_exception,
   input  logic               mem_busy,
   output logic [NUM_EXT-1:0] ext_start,
   output logic [NUM_EXT-1:0] ext_grant,
   output logic               active_insn,
   output logic               execute_stall,
   output logic               memory_stall,
   output logic               ex_token,
   output logic               exception,
   output logic [NUM_EXT-1:0] ex_cause,
   output logic               timeout
);

   rmgmt_seq_state_t  state;
   logic [NUM_EXT-1:0] claim_sel;
   logic               claim_any;
   logic               start_flag;
   logic [WD_W-1:0]    wd_cnt;
   logic               accept, own_exc, own_done, own_mem, wd_fire;

   rmgmt_prio_enc #(.W(NUM_EXT)) u_enc (
      .req       (ext_claim),
      .sel       (claim_sel),
      .any_valid (claim_any)
   );

   // Accept is gated by nRST so every output is quiet while reset is held.
   assign accept   = nRST && (state == IDLE) && insn_valid && claim_any && !pipe_stall && !flush;
   assign own_exc  = |(ext_exception & ext_grant);
   assign own_done = |(ext_done & ext_grant);
   assign own_mem  = |(ext_mem_req & ext_grant);
   assign wd_fire  = (wd_cnt == WD_W'(TIMEOUT - 1));

   always_comb begin
      ext_start     = '0;
      active_insn   = 1'b0;
      execute_stall = 1'b0;
      memory_stall  = 1'b0;
      ex_token      = 1'b0;
      exception     = 1'b0;
      ex_cause      = '0;
      timeout       = 1'b0;
      case (state)
         IDLE: execute_stall = accept;
         EXEC: begin
            active_insn = 1'b1;
            if (start_flag) ext_start = ext_grant;
            if (flush) begin
               // squash: nothing reported
            end else if (own_exc) begin
               exception = 1'b1;
               ex_cause  = ext_grant;
            end else if (wd_fire) begin
               exception = 1'b1;
               ex_cause  = ext_grant;
               timeout   = 1'b1;
            end else if (own_done) begin
               ex_token = 1'b1;
            end
            execute_stall = !ex_token;
         end
         MEM: begin
            active_insn   = 1'b1;
            execute_stall = 1'b1;
            memory_stall  = mem_busy;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         ext_grant  <= '0;
         wd_cnt     <= '0;
         start_flag <= 1'b0;
      end else begin
         start_flag <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               state      <= EXEC;
               ext_grant  <= claim_sel;
               wd_cnt     <= '0;
               start_flag <= 1'b1;
            end
            EXEC: begin
               wd_cnt <= wd_cnt + WD_W'(1);
               if (flush || own_exc || wd_fire || own_done) begin
                  state     <= IDLE;
                  ext_grant <= '0;
               end else if (own_mem) begin
                  state <= MEM;
               end
            end
            MEM: begin
               // Watchdog holds its value while the memory phase runs.
               if (flush) begin
                  state     <= IDLE;
                  ext_grant <= '0;
               end else if (!mem_busy) begin
                  state <= EXEC;
               end
            end
            default: begin
               state     <= IDLE;
               ext_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rmgmt_ext_sequencer.sv
// Randomized scoreboard bench for rmgmt_ext_sequencer.
module tb_rmgmt_ext_sequencer;
   localparam int N  = 4;
   localparam int TO = 255;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         insn_valid, pipe_stall, flush, mem_busy;
   logic [N-1:0] ext_claim, ext_done, ext_mem_req, ext_exception;
   logic [N-1:0] ext_start, ext_grant, ex_cause;
   logic         active_insn, execute_stall, memory_stall, ex_token, exception, timeout;

   always #5 CLK = ~CLK;

   rmgmt_ext_sequencer #(.NUM_EXT(N), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST), .insn_valid(insn_valid), .ext_claim(ext_claim),
      .pipe_stall(pipe_stall), .flush(flush), .ext_done(ext_done),
      .ext_mem_req(ext_mem_req), .ext_exception(ext_exception), .mem_busy(mem_busy),
      .ext_start(ext_start), .ext_grant(ext_grant), .active_insn(active_insn),
      .execute_stall(execute_stall), .memory_stall(memory_stall), .ex_token(ex_token),
      .exception(exception), .ex_cause(ex_cause), .timeout(timeout)
   );

   // kind: 0 = start pulse, 1 = retire token, 2 = exception
   typedef struct {
      int           kind;
      logic [N-1:0] val;
      logic         to;
   } ev_t;

   ev_t sbq[$];
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void push(input int k, input logic [N-1:0] v, input logic t);
      ev_t e;
      e.kind = k; e.val = v; e.to = t;
      sbq.push_back(e);
   endfunction

   task automatic mon(input int k, input logic [N-1:0] v, input logic t);
      ev_t e;
      tests++;
      if (sbq.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d val %b to %b, expected none", k, v, t);
      end else begin
         e = sbq.pop_front();
         if (e.kind != k || e.val !== v || e.to !== t) begin
            fails++;
            $display("FAIL event: got kind %0d val %b to %b, expected kind %0d val %b to %b",
                     k, v, t, e.kind, e.val, e.to);
         end
      end
   endtask

   // Monitor: any pulse the DUT shows is matched against the scoreboard.
   always @(negedge CLK) begin
      if (ext_start != '0) mon(0, ext_start, 1'b0);
      if (ex_token === 1'b1) mon(1, '0, 1'b0);
      if (exception === 1'b1) mon(2, ex_cause, timeout);
      chk("token_excl", {31'd0, exception & ex_token}, 0);
      chk("grant_onehot", ($countones(ext_grant) <= 1) ? 1 : 0, 1);
   end

   // Reference: owner is the lowest-numbered claimant.
   function automatic logic [N-1:0] ref_owner(input logic [N-1:0] claim);
      for (int i = 0; i < N; i++)
         if (claim[i]) return N'(1) << i;
      return '0;
   endfunction

   function automatic logic [N-1:0] noise(input logic [N-1:0] own);
      return N'($urandom) & ~own;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_in();
      insn_valid = 0; ext_claim = '0; pipe_stall = 0; flush = 0; mem_busy = 0;
      ext_done = '0; ext_mem_req = '0; ext_exception = '0;
   endtask

   task automatic drive_noise(input logic [N-1:0] own);
      ext_done = noise(own); ext_exception = noise(own); ext_mem_req = noise(own);
      flush = 0; pipe_stall = 0; mem_busy = $urandom;
      insn_valid = $urandom; ext_claim = N'($urandom);
   endtask

   task automatic idle_cycle();
      int r;
      r = $urandom % 4;
      clear_in();
      insn_valid = 1; ext_claim = N'($urandom);
      case (r)
         0: insn_valid = 0;
         1: ext_claim  = '0;
         2: pipe_stall = 1;
         default: flush = 1;
      endcase
      @(negedge CLK);
      chk("idle_stall", {31'd0, execute_stall}, 0);
      chk("idle_active", {31'd0, active_insn}, 0);
      chk("idle_grant", ext_grant, 0);
      step();
   endtask

   // kind: 0 done, 1 exception (+owner done), 2 flush in EXEC, 3 flush in MEM, 4 watchdog
   task automatic run_insn(input logic [N-1:0] claim, input int kind, input int pre, input int mem_cyc);
      logic [N-1:0] own;
      int nexec;
      own = ref_owner(claim);
      nexec = 0;
      drive_noise(own);
      insn_valid = 1; ext_claim = claim;
      push(0, own, 1'b0);
      @(negedge CLK);
      chk("acc_stall", {31'd0, execute_stall}, 1);
      chk("acc_grant", ext_grant, 0);
      chk("acc_active", {31'd0, active_insn}, 0);
      chk("acc_mstall", {31'd0, memory_stall}, 0);
      step();
      for (int c = 0; c < pre; c++) begin
         drive_noise(own); nexec++;
         @(negedge CLK);
         chk("exec_stall", {31'd0, execute_stall}, 1);
         chk("exec_active", {31'd0, active_insn}, 1);
         chk("exec_grant", ext_grant, own);
         step();
      end
      if (mem_cyc >= 0) begin
         drive_noise(own); ext_mem_req = ext_mem_req | own; nexec++;
         @(negedge CLK);
         chk("memreq_stall", {31'd0, execute_stall}, 1);
         step();
         for (int c = 0; c <= mem_cyc; c++) begin
            drive_noise(own);
            mem_busy = (c < mem_cyc);
            if (kind == 3) begin
               flush = 1;
               ext_done = ext_done | (~own & N'(1));
            end
            @(negedge CLK);
            chk("mem_mstall", {31'd0, memory_stall}, {31'd0, mem_busy});
            chk("mem_estall", {31'd0, execute_stall}, 1);
            chk("mem_grant", ext_grant, own);
            step();
            if (kind == 3) begin
               clear_in();
               @(negedge CLK);
               chk("flush_grant", ext_grant, 0);
               chk("flush_active", {31'd0, active_insn}, 0);
               step();
               return;
            end
         end
      end
      if (kind == 4) begin
         while (nexec < TO - 1) begin
            drive_noise(own); nexec++;
            @(negedge CLK);
            chk("wd_stall", {31'd0, execute_stall}, 1);
            step();
         end
      end
      drive_noise(own);
      case (kind)
         0: begin
            ext_done = ext_done | own;
            if ($urandom % 2) ext_mem_req = ext_mem_req | own;
            push(1, '0, 1'b0);
         end
         1: begin
            ext_exception = ext_exception | own;
            ext_done = ext_done | own;
            push(2, own, 1'b0);
         end
         2: begin
            flush = 1;
            if ($urandom % 2) ext_done = ext_done | own;
            if ($urandom % 2) ext_exception = ext_exception | own;
         end
         default: begin
            if ($urandom % 2) ext_done = ext_done | own;
            push(2, own, 1'b1);
         end
      endcase
      @(negedge CLK);
      if (kind == 0) chk("done_stall", {31'd0, execute_stall}, 0);
      step();
      clear_in();
   endtask

   initial begin
      logic [N-1:0] claim;
      int kind, pre, mc;
      clear_in();
      nRST = 0;
      @(negedge CLK);
      chk("reset_outs", {ext_start, ext_grant, ex_cause, active_insn, execute_stall,
                         memory_stall, ex_token, exception, timeout}, 0);
      @(posedge CLK); #1;
      nRST = 1;
      @(negedge CLK);
      chk("post_reset_grant", ext_grant, 0);
      step();

      run_insn(4'b0110, 0, 0, -1);
      run_insn(4'b0100, 0, 1, 3);
      run_insn(4'b1000, 1, 0, -1);
      run_insn(4'b0110, 3, 0, 2);
      run_insn(4'b0001, 4, 0, -1);
      chk("sb_drained_dir", sbq.size(), 0);

      // Reset mid-EXEC with the owner trying to complete.
      insn_valid = 1; ext_claim = 4'b0110;
      push(0, 4'b0010, 1'b0);
      step();
      clear_in();
      step();
      #2;
      nRST = 0;
      ext_done = 4'b0010;
      #1;
      chk("midrst_outs", {ext_start, ext_grant, ex_cause, active_insn, execute_stall,
                          memory_stall, ex_token, exception, timeout}, 0);
      @(posedge CLK); #1;
      clear_in();
      nRST = 1;
      @(negedge CLK);
      chk("midrst_grant", ext_grant, 0);
      chk("midrst_active", {31'd0, active_insn}, 0);
      step();

      repeat (60) begin
         repeat ($urandom % 3) idle_cycle();
         claim = N'($urandom_range(1, (1 << N) - 1));
         kind  = $urandom % 4;
         if ($urandom % 25 == 0) kind = 4;
         pre   = $urandom % 4;
         mc    = ($urandom % 2) ? int'($urandom % 4) : -1;
         if (kind == 3 && mc < 0) mc = $urandom % 3;
         run_insn(claim, kind, pre, mc);
         chk("sb_drained", sbq.size(), 0);
      end

      chk("sb_final", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
